// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: block size, round count, S-box, Rcon and word helpers
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

    localparam int AES_BLOCK_W = `AES_BLOCK_SIZE;
    localparam int AES_ROUNDS  = 10;
    localparam logic [3:0] AES_LAST_ROUND = 4'(AES_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant positioned in the top byte of a word; zero outside rounds 1..10.
    function automatic logic [31:0] rcon_word(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    // Word 0 sits in the most significant 32 bits of the block.
    function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] idx);
        return blk[{~idx, 5'b0} +: 32];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box lookup on one byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);

    assign subst = SBOX[data];

endmodule

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: four S-box lookups across one 32-bit word
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (word[8*i +: 8]),
            .subst (sub[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 decrypt key schedule streaming round keys 10..0; optional AES_INV_KS_CACHE_EN
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [AES_BLOCK_W-1:0] key,
    output logic                   round_key_valid,
    input  logic                   round_key_ready,
    output logic [AES_BLOCK_W-1:0] round_key,
    output logic [3:0]             round_idx,
    output logic                   round_last
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_EMIT} state_t;

    state_t       state, state_nxt;
    logic [127:0] key_reg;
    logic [3:0]   cnt;
    logic         key_hs, rk_hs, cache_hit;
    logic [127:0] hit_key;

    logic [31:0]  w0, w1, w2, w3, w1p, w2p, w3p;
    logic [31:0]  sw_in, sw_out, fwd_t, f0, f1, f2, f3;
    logic [127:0] fwd_key, bwd_key;

    assign w0 = get_word(key_reg, 2'd0);
    assign w1 = get_word(key_reg, 2'd1);
    assign w2 = get_word(key_reg, 2'd2);
    assign w3 = get_word(key_reg, 2'd3);

    assign w3p = w3 ^ w2;
    assign w2p = w2 ^ w1;
    assign w1p = w1 ^ w0;

    // One SubWord serves both directions: forward while expanding, backward while emitting.
    assign sw_in = rot_word((state == ST_EMIT) ? w3p : w3);

    aes_sub_word u_sub_word (
        .word (sw_in),
        .sub  (sw_out)
    );

    assign fwd_t   = sw_out ^ rcon_word(cnt);
    assign f0      = w0 ^ fwd_t;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign bwd_key = {w0 ^ sw_out ^ rcon_word(round_idx), w1p, w2p, w3p};

    assign key_hs = key_valid && (state == ST_IDLE);
    assign rk_hs  = round_key_ready && (state == ST_EMIT);

`ifdef AES_INV_KS_CACHE_EN
    logic [127:0] cache_key, cache_rk10;
    logic         cache_vld;

    assign cache_hit = cache_vld && (key == cache_key);
    assign hit_key   = cache_rk10;

    // A missed key invalidates the cache until its own expansion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
        end else begin
            if (key_hs && !cache_hit) begin
                cache_key <= key;
                cache_vld <= 1'b0;
            end
            if (state == ST_EXPAND && cnt == AES_LAST_ROUND) begin
                cache_rk10 <= fwd_key;
                cache_vld  <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_key   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (key_hs) state_nxt = cache_hit ? ST_EMIT : ST_EXPAND;
            ST_EXPAND: if (cnt == AES_LAST_ROUND) state_nxt = ST_EMIT;
            ST_EMIT:   if (rk_hs && round_idx == 4'd0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= '0;
            cnt       <= '0;
            round_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_hs) begin
                        if (cache_hit) begin
                            key_reg   <= hit_key;
                            round_idx <= AES_LAST_ROUND;
                        end else begin
                            key_reg <= key;
                            cnt     <= 4'd1;
                        end
                    end
                end
                ST_EXPAND: begin
                    key_reg <= fwd_key;
                    cnt     <= cnt + 4'd1;
                    if (cnt == AES_LAST_ROUND) round_idx <= AES_LAST_ROUND;
                end
                ST_EMIT: begin
                    if (rk_hs && round_idx != 4'd0) begin
                        key_reg   <= bwd_key;
                        round_idx <= round_idx - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_ready       = (state == ST_IDLE);
        round_key_valid = (state == ST_EMIT);
        round_last      = (state == ST_EMIT) && (round_idx == 4'd0);
        round_key       = key_reg;
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - scoreboard bench for aes_inv_key_schedule
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = '0;
    logic         round_key_valid;
    logic         round_key_ready = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         round_last;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [127:0] key;
        int           idx;
        bit           last;
        bit           chk_key;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

`ifdef AES_INV_KS_CACHE_EN
    localparam int REPEAT_LAT = 1;
`else
    localparam int REPEAT_LAT = 11;
`endif

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .key             (key),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .round_key       (round_key),
        .round_idx       (round_idx),
        .round_last      (round_last)
    );

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_blk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_fips(input int lo);
        for (int i = 10; i >= lo; i--) sb.push_back('{FIPS_RK[i], i, (i == 0), 1'b1});
    endtask

    task automatic push_zero();
        sb.push_back('{ZERO_RK10, 10, 1'b0, 1'b1});
        for (int i = 9; i >= 1; i--) sb.push_back('{128'h0, i, 1'b0, 1'b0});
        sb.push_back('{ZERO_KEY, 0, 1'b1, 1'b1});
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic accept_key(input logic [127:0] k);
        int w;
        w = 0;
        while (!key_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check_int("key_ready_before_accept", int'(key_ready), 1);
        key = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic measure_lat(input string name, input int start, input int req);
        int lat;
        lat = start;
        while (!round_key_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_int(name, lat, req);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_int({name, "_drain"}, sb.size(), 0);
        sb.delete();
        check_int({name, "_valid_low"}, int'(round_key_valid), 0);
        check_int({name, "_ready_high"}, int'(key_ready), 1);
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            if (rand_ready) round_key_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        exp_t         e;
        bit           stalled;
        logic [127:0] hold_key;
        logic [3:0]   hold_idx;
        stalled = 1'b0;
        hold_key = '0;
        hold_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check_int("stall_valid", int'(round_key_valid), 1);
                    check_blk("stall_key", round_key, hold_key);
                    check_int("stall_idx", int'(round_idx), int'(hold_idx));
                end
                stalled  = round_key_valid && !round_key_ready;
                hold_key = round_key;
                hold_idx = round_idx;
                if (round_key_valid && round_key_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_key actual idx=%0d required=none", round_idx);
                    end else begin
                        e = sb.pop_front();
                        check_int("idx", int'(round_idx), e.idx);
                        check_int($sformatf("last_idx%0d", e.idx), int'(round_last), int'(e.last));
                        if (e.chk_key) check_blk($sformatf("key_idx%0d", e.idx), round_key, e.key);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int stray;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_key_ready", int'(key_ready), 1);
        check_int("rst_valid", int'(round_key_valid), 0);
        check_blk("rst_round_key", round_key, 128'h0);
        check_int("rst_idx", int'(round_idx), 0);
        check_int("rst_last", int'(round_last), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vector, consumer always ready
        round_key_ready = 1'b1;
        push_fips(0);
        accept_key(FIPS_KEY);
        measure_lat("lat_fips", 1, 11);
        wait_done("fips");

        // different key offered during EXPAND and EMIT of the all-zero key
        push_zero();
        accept_key(ZERO_KEY);
        key = FIPS_KEY;
        key_valid = 1'b1;
        check_int("ready_in_expand", int'(key_ready), 0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        measure_lat("lat_zero", 2, 11);
        key_valid = 1'b1;
        check_int("ready_in_emit", int'(key_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_done("zero");
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (round_key_valid) stray++;
        end
        check_int("no_stray_stream", stray, 0);

        // random backpressure on the FIPS vector
        rand_ready = 1'b1;
        push_fips(0);
        accept_key(FIPS_KEY);
        measure_lat("lat_fips_bp", 1, 11);
        wait_done("fips_bp");
        rand_ready = 1'b0;
        @(posedge clk); #1;
        round_key_ready = 1'b1;

        // immediate repeat of the same key, then a different key
        push_fips(0);
        accept_key(FIPS_KEY);
        measure_lat("lat_fips_repeat", 1, REPEAT_LAT);
        wait_done("fips_repeat");
        push_zero();
        accept_key(ZERO_KEY);
        measure_lat("lat_zero_after_hit", 1, 11);
        wait_done("zero2");

        // reset while round key 5 is presented
        push_fips(6);
        accept_key(FIPS_KEY);
        n = 0;
        while (!(round_key_valid && round_idx == 4'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_int("reach_idx5", int'(round_idx), 5);
        rst_n = 1'b0;
        #1;
        check_int("reset_valid_drop", int'(round_key_valid), 0);
        check_int("reset_key_ready", int'(key_ready), 1);
        check_int("pre_reset_drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("post_reset_ready", int'(key_ready), 1);
        check_int("post_reset_idx", int'(round_idx), 0);
        check_int("post_reset_valid", int'(round_key_valid), 0);
        push_fips(0);
        accept_key(FIPS_KEY);
        measure_lat("lat_after_reset", 1, 11);
        wait_done("fips_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
